// File: rtl/led_pattern_pkg.sv
// Shared definitions for the LED pattern generator: mode codes, direction
// constants and the per-mode seed value loaded on reset and on mode change.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_JOHNSON = 2'd0,
    MODE_RING    = 2'd1,
    MODE_BOUNCE  = 2'd2,
    MODE_COUNT   = 2'd3
  } mode_t;

  // Direction encoding shared by the dir input and the internal bounce state.
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // The seed is returned at a fixed maximum width; callers size-cast it down.
  localparam int SEED_W = 64;

  // Starting pattern for a mode: one-hot bit 0 for the rotating patterns,
  // all-zero for the Johnson counter and the binary counter.
  function automatic logic [SEED_W-1:0] seed(input mode_t mode, input int width);
    logic [SEED_W-1:0] s;
    s = '0;
    if ((width >= 1) && ((mode == MODE_RING) || (mode == MODE_BOUNCE))) begin
      s = SEED_W'(1);
    end
    return s;
  endfunction

endpackage

// File: rtl/led_pattern_gen_tick_prescaler.sv
// Step-rate prescaler: divides CLK by max(DIV >> speed, 1) and raises adv in
// the cycle whose edge should advance the pattern.
import led_pattern_pkg::*;

module tick_prescaler #(
  parameter int DIV   = 25_000_000,
  parameter int DIV_W = $clog2(DIV + 1)
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [2:0] speed,
  output logic       adv
);

  localparam logic [DIV_W-1:0] DIV_V = DIV_W'(DIV);
  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);

  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] shifted;
  logic [DIV_W-1:0] period;
  logic             at_end;

  // Current period, clamped to one cycle when the shift empties DIV.
  // NOTE: every always_comb output gets a default on every path so no latch is inferred.
  always_comb begin
    shifted = DIV_V >> speed;
    period  = (shifted == '0) ? ONE : shifted;
  end

  // Using >= rather than == means a mid-period speed-up fires on the next
  // edge instead of wrapping the whole counter range.
  assign at_end = (count >= (period - ONE));
  assign adv    = en && !clr && at_end;

  // Period counter; a mode change restarts it so the first advance of the new
  // mode lands a full period later. Pause simply holds it.
  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= at_end ? '0 : (count + ONE);
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: steps a Johnson, ring, bounce or binary-count pattern
// across a WIDTH-bit LED bank at a programmable rate, with pause and
// single-step control. WIDTH must be at least 2 and DIV at least 1.
import led_pattern_pkg::*;

module led_pattern_gen #(
  parameter int WIDTH = 18,
  parameter int DIV   = 25_000_000,
  parameter int DIV_W = $clog2(DIV + 1)
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             en,
  input  logic             step,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic [2:0]       speed,
  output logic [WIDTH-1:0] pattern,
  output logic             tick
);

  mode_t            mode_q;
  mode_t            mode_in;
  logic             bounce_dir;
  logic             mode_chg;
  logic             adv;
  logic             do_step;
  logic [WIDTH-1:0] seed_val;
  logic [WIDTH-1:0] next_pattern;
  logic             next_bounce_dir;
  logic [WIDTH-1:0] shl;
  logic [WIDTH-1:0] shr;

  assign mode_in  = mode_t'(mode);
  assign mode_chg = (mode_in != mode_q);
  assign seed_val = WIDTH'(seed(mode_in, WIDTH));
  // A manual step only counts while paused; while running it is ignored.
  assign do_step  = step && !en;

  tick_prescaler #(
    .DIV   (DIV),
    .DIV_W (DIV_W)
  ) u_prescaler (
    .CLK   (CLK),
    .rst   (rst),
    .en    (en),
    .clr   (mode_chg),
    .speed (speed),
    .adv   (adv)
  );

  // Next pattern value for the registered mode; dir is sampled here at every
  // advance, so flipping it mid-sequence continues from the current value.
  always_comb begin
    next_pattern    = pattern;
    next_bounce_dir = bounce_dir;
    shl             = {pattern[WIDTH-2:0], 1'b0};
    shr             = {1'b0, pattern[WIDTH-1:1]};
    unique case (mode_q)
      MODE_JOHNSON: begin
        if (dir == DIR_LEFT) next_pattern = {pattern[WIDTH-2:0], ~pattern[WIDTH-1]};
        else                 next_pattern = {~pattern[0], pattern[WIDTH-1:1]};
      end
      MODE_RING: begin
        if (dir == DIR_LEFT) next_pattern = {pattern[WIDTH-2:0], pattern[WIDTH-1]};
        else                 next_pattern = {pattern[0], pattern[WIDTH-1:1]};
      end
      MODE_BOUNCE: begin
        // Direction flips on the step that lands on an end bit, so the ends
        // are shown once per sweep (sequence length 2W-2).
        if (bounce_dir == DIR_LEFT) begin
          next_pattern    = shl;
          next_bounce_dir = shl[WIDTH-1] ? DIR_RIGHT : DIR_LEFT;
        end else begin
          next_pattern    = shr;
          next_bounce_dir = shr[0] ? DIR_LEFT : DIR_RIGHT;
        end
      end
      MODE_COUNT: begin
        if (dir == DIR_LEFT) next_pattern = pattern + WIDTH'(1);
        else                 next_pattern = pattern - WIDTH'(1);
      end
      default: next_pattern = pattern;
    endcase
  end

  // Pattern, tick and mode tracking. Priority: reset, then mode change, then
  // an advance from the prescaler or a paused single step.
  always_ff @(posedge CLK) begin
    if (!rst) begin
      pattern    <= seed_val;
      tick       <= 1'b0;
      bounce_dir <= DIR_LEFT;
      mode_q     <= mode_in;
    end else if (mode_chg) begin
      pattern    <= seed_val;
      tick       <= 1'b0;
      bounce_dir <= DIR_LEFT;
      mode_q     <= mode_in;
    end else if (adv || do_step) begin
      pattern    <= next_pattern;
      tick       <= 1'b1;
      bounce_dir <= next_bounce_dir;
    end else begin
      tick       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen at WIDTH = 4, DIV = 4. A table of
// per-cycle vectors (inputs applied before an edge, expected outputs after it)
// is built up scenario by scenario, then replayed and compared in one loop.
module tb_led_pattern_gen;

  logic       clk;
  logic       rst;
  logic       en;
  logic       step;
  logic [1:0] mode;
  logic       dir;
  logic [2:0] speed;
  logic [3:0] pattern;
  logic       tick;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic       step;
    logic [1:0] mode;
    logic       dir;
    logic [2:0] speed;
    logic [3:0] exp_p;
    logic       exp_t;
    string      name;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] last_p;

  led_pattern_gen #(
    .WIDTH (4),
    .DIV   (4)
  ) dut (
    .CLK     (clk),
    .rst     (rst),
    .en      (en),
    .step    (step),
    .mode    (mode),
    .dir     (dir),
    .speed   (speed),
    .pattern (pattern),
    .tick    (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic s, input logic [1:0] m,
                     input logic d, input logic [2:0] sp, input logic [3:0] p,
                     input logic t, input string nm);
    vec_t v;
    v.rst = r; v.en = e; v.step = s; v.mode = m; v.dir = d; v.speed = sp;
    v.exp_p = p; v.exp_t = t; v.name = nm;
    vecs.push_back(v);
    last_p = p;
  endtask

  // One full period while running: period-1 quiet edges, then the advance.
  task automatic add_adv(input logic [1:0] m, input logic d, input logic [2:0] sp,
                         input int period, input logic [3:0] p, input string nm);
    for (int i = 0; i < period - 1; i++) add(1, 1, 0, m, d, sp, last_p, 0, nm);
    add(1, 1, 0, m, d, sp, p, 1, nm);
  endtask

  initial begin
    logic [3:0] john[8];
    logic [3:0] bnc[7];
    rst = 1'b0; en = 1'b1; step = 1'b0; mode = 2'd0; dir = 1'b0; speed = 3'd0;
    last_p = 4'b0000;

    // Johnson left from reset, period 4.
    john = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    add(0, 1, 0, 0, 0, 0, 4'b0000, 0, "rst_john");
    add(0, 1, 0, 0, 0, 0, 4'b0000, 0, "rst_john");
    for (int i = 0; i < 8; i++) add_adv(0, 0, 0, 4, john[i], "john_left");

    // Bounce via mode change, dir toggled every step and ignored.
    bnc = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    add(1, 1, 0, 2, 0, 0, 4'b0001, 0, "mchg_bounce");
    for (int i = 0; i < 7; i++) add_adv(2, 1'(i % 2 == 0), 0, 4, bnc[i], "bounce");

    // Count down from reset, then up through the wrap.
    add(0, 1, 0, 3, 1, 0, 4'b0000, 0, "rst_count");
    add_adv(3, 1, 0, 4, 4'b1111, "count_down");
    add_adv(3, 1, 0, 4, 4'b1110, "count_down");
    add_adv(3, 0, 0, 4, 4'b1111, "count_up");
    add_adv(3, 0, 0, 4, 4'b0000, "count_wrap");

    // Ring to 0100, then switch to COUNT two cycles into a period.
    add(1, 1, 0, 1, 0, 0, 4'b0001, 0, "mchg_ring");
    add_adv(1, 0, 0, 4, 4'b0010, "ring_left");
    add_adv(1, 0, 0, 4, 4'b0100, "ring_left");
    add(1, 1, 0, 1, 0, 0, 4'b0100, 0, "ring_mid");
    add(1, 1, 0, 1, 0, 0, 4'b0100, 0, "ring_mid");
    add(1, 1, 0, 3, 0, 0, 4'b0000, 0, "mchg_count");
    add_adv(3, 0, 0, 4, 4'b0001, "mchg_first_adv");

    // Rates: speed 1 -> period 2, speed 3 -> period 1 (tick held high).
    add_adv(3, 0, 1, 2, 4'b0010, "speed1");
    add_adv(3, 0, 1, 2, 4'b0011, "speed1");
    add_adv(3, 0, 3, 1, 4'b0100, "speed3");
    add_adv(3, 0, 3, 1, 4'b0101, "speed3");
    add_adv(3, 0, 3, 1, 4'b0110, "speed3");
    // Speed 0 -> 2 with count at 2: advance on the very next edge.
    add(1, 1, 0, 3, 0, 0, 4'b0110, 0, "pre_speedup");
    add(1, 1, 0, 3, 0, 0, 4'b0110, 0, "pre_speedup");
    add(1, 1, 0, 3, 0, 2, 4'b0111, 1, "speedup");
    add(1, 1, 0, 3, 0, 2, 4'b1000, 1, "speed2");

    // Pause with count at 2; a step advances once and leaves count alone.
    add(1, 1, 0, 3, 0, 0, 4'b1000, 0, "pre_pause");
    add(1, 1, 0, 3, 0, 0, 4'b1000, 0, "pre_pause");
    for (int i = 0; i < 5; i++) add(1, 0, 0, 3, 0, 0, 4'b1000, 0, "pause_hold");
    add(1, 0, 1, 3, 0, 0, 4'b1001, 1, "step");
    add(1, 0, 0, 3, 0, 0, 4'b1001, 0, "post_step");
    add(1, 0, 0, 3, 0, 0, 4'b1001, 0, "post_step");
    add(1, 1, 0, 3, 0, 0, 4'b1001, 0, "resume");
    add(1, 1, 0, 3, 0, 0, 4'b1010, 1, "resume_adv");
    // Step while running is ignored.
    add(1, 1, 1, 3, 0, 0, 4'b1010, 0, "step_running");
    add(1, 1, 1, 3, 0, 0, 4'b1010, 0, "step_running");
    add(1, 1, 0, 3, 0, 0, 4'b1010, 0, "step_running");
    add(1, 1, 0, 3, 0, 0, 4'b1011, 1, "step_running_adv");

    // Reset at count 3 in COUNT at 0110 aborts the pending advance.
    add(0, 1, 0, 3, 0, 0, 4'b0000, 0, "rst_count2");
    add_adv(3, 0, 3, 1, 4'b0001, "fast");
    add_adv(3, 0, 3, 1, 4'b0010, "fast");
    add_adv(3, 0, 3, 1, 4'b0011, "fast");
    add_adv(3, 0, 3, 1, 4'b0100, "fast");
    add_adv(3, 0, 3, 1, 4'b0101, "fast");
    add_adv(3, 0, 3, 1, 4'b0110, "fast");
    for (int i = 0; i < 3; i++) add(1, 1, 0, 3, 0, 0, 4'b0110, 0, "pre_rst");
    add(0, 1, 0, 3, 0, 0, 4'b0000, 0, "rst_mid");
    add_adv(3, 0, 0, 4, 4'b0001, "post_rst_adv");

    // Right-going ring and Johnson.
    add(1, 1, 0, 1, 1, 3, 4'b0001, 0, "mchg_ring_r");
    add_adv(1, 1, 3, 1, 4'b1000, "ring_right");
    add_adv(1, 1, 3, 1, 4'b0100, "ring_right");
    add(1, 1, 0, 0, 1, 3, 4'b0000, 0, "mchg_john_r");
    add_adv(0, 1, 3, 1, 4'b1000, "john_right");
    add_adv(0, 1, 3, 1, 4'b1100, "john_right");
    add_adv(0, 1, 3, 1, 4'b1110, "john_right");

    // Replay the table.
    foreach (vecs[i]) begin
      rst = vecs[i].rst; en = vecs[i].en; step = vecs[i].step;
      mode = vecs[i].mode; dir = vecs[i].dir; speed = vecs[i].speed;
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d].pattern", vecs[i].name, i), 32'(pattern), 32'(vecs[i].exp_p));
      check($sformatf("%s[%0d].tick", vecs[i].name, i), 32'(tick), 32'(vecs[i].exp_t));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern generator for the DE2 demo top level. Drives a WIDTH-bit LED bank, stepping a selectable pattern (Johnson, ring, bounce, binary count) at a programmable rate. An internal prescaler derives the step rate from CLK. Switch and key inputs give run/pause, single-step, direction and speed control.

## Interface
Parameters:
- WIDTH, 18, pattern width in bits; must be ≥ 2.
- DIV, 25_000_000, base step period in CLK cycles at speed 0; must be ≥ 1.
- DIV_W, $clog2(DIV+1), prescaler counter width; derived, do not override.

Ports:
- CLK  in  1  system clock.
- rst  in  1  reset, synchronous, active-low.
- en  in  1  1 = run, 0 = pause (prescaler and pattern hold).
- step  in  1  single-cycle pulse; advances the pattern one step while en = 0, ignored while en = 1.
- mode  in  2  0 JOHNSON, 1 RING, 2 BOUNCE, 3 COUNT.
- dir  in  1  0 = left/up, 1 = right/down; ignored in BOUNCE.
- speed  in  3  step period = max(DIV >> speed, 1) cycles.
- pattern  out  WIDTH  LED drive, registered.
- tick  out  1  registered; high for the one cycle in which pattern shows a newly advanced value.

## Operation
Reset (rst = 0 at an edge) sets the following values:
- pattern = seed(mode); tick = 0; prescaler count = 0; bounce_dir = left; mode_q = mode.

Seeds:
- JOHNSON 0.
- RING 1.
- BOUNCE 1 (bounce_dir left).
- COUNT 0.

Advance rules, with W = WIDTH:
- JOHNSON: left p ← {p[W-2:0], ~p[W-1]}; right p ← {~p[0], p[W-1:1]}. Sequence length is 2W.
- RING: rotate left or right by one, according to dir.
- BOUNCE: one-hot bit moves in the bounce_dir direction.
  - bounce_dir flips on the step that reaches bit W-1 or bit 0.
  - Sequence length is 2W-2.
- COUNT: p ± 1 modulo 2^W; up when dir = 0, down when dir = 1.

Mode change:
- When mode ≠ mode_q, the next edge sets pattern = seed(mode), count = 0, mode_q = mode and tick = 0.
- Mode change has priority over a coincident advance or step.

Prescaler:
- period = max(DIV >> speed, 1).
- At each edge with en = 1: if count ≥ period-1, then count ← 0 and advance; otherwise count ← count + 1.
- Using ≥ means a speed increase mid-period advances on the next edge, with no long wrap.

Pause:
- With en = 0, count and pattern hold.
- A step pulse advances once on the next edge and does not touch count.
- Priority order: rst > mode change > advance (tick or step).

dir is sampled at each advance; changing dir mid-sequence continues from the current pattern.

## Timing
- Single clock domain. All outputs are registered, with no combinational input-to-output paths.
- Advance latency: pattern changes at exactly every period-th edge after reset release or mode change (count 0 → period-1).
- Step latency is 1 cycle.
- tick = 1 in the same cycle as the new pattern value, and 0 otherwise. With period = 1, tick is constantly high while en = 1.
- rst asserted mid-period aborts the period: outputs take their reset values at that edge.
- step, en, mode, dir and speed are treated as synchronous to CLK. Synchronising and debouncing KEY/SW is the top level's job.

## Structure
- Package led_pattern_pkg holds:
  - mode codes (MODE_JOHNSON = 0, MODE_RING = 1, MODE_BOUNCE = 2, MODE_COUNT = 3);
  - the seed function seed(mode, WIDTH);
  - the direction constants.
- Sub-module tick_prescaler (params DIV, DIV_W) contains:
  - inputs CLK, rst, en, clr, speed;
  - output adv, a one-cycle pulse.
- The pattern register, mode_q and bounce_dir stay in led_pattern_gen.

## Test plan
All scenarios use WIDTH = 4, DIV = 4, en = 1 and speed = 0 unless noted.
- JOHNSON, dir = 0, release rst: pattern 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, changing every 4 cycles. tick pulses one cycle with each change.
- BOUNCE: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010. dir toggling is ignored.
- COUNT, dir = 1 from reset: 1111, then 1110. Switching dir to 0 at 1110 gives 1111, then 0000 (wrap).
- Mode change: RING at 0100, two cycles into a period, then mode → COUNT. Next edge gives 0000 with tick = 0; the first advance to 0001 comes exactly 4 edges later.
- Rate and pause:
  - speed = 1 gives period 2; speed = 3 gives period 1 (4 >> 3 = 0 → 1).
  - Raising speed 0 → 2 at count = 2 advances on the next edge.
  - en = 0 holds pattern indefinitely; a step pulse advances exactly one step; step with en = 1 has no extra effect.
- Reset mid-operation: in COUNT at 0110, with count = 3 coincident with rst = 0. Next edge gives pattern 0000 and tick = 0, with no advance.
